// File: rtl/pe_sequencer_if.sv
// pe_sequencer_if
// ---------------
// Bundles the job-control, feeder handshake and PE central-control signals of
// the pe_sequencer so the sequencer, its feeder and the PE grid share a single
// connection.
//
// Modports:
//   master : the feeder/ingress side; drives start, cfg_num_vec, cfg_num_pass,
//            in_valid and drain_almfull, and observes everything else.
//   slave  : the sequencer itself; drives in_rdy, ena, acc_res, acc_fin,
//            acc_stop, busy, done, cfg_err and perf_stall.
interface pe_sequencer_if #(
    parameter int FEED_DEPTH = 1024,
    parameter int PASS_WIDTH = 16
);
    localparam int VEC_W = $clog2(FEED_DEPTH + 1);

    logic                  start;
    logic [VEC_W-1:0]      cfg_num_vec;
    logic [PASS_WIDTH-1:0] cfg_num_pass;
    logic                  in_valid;
    logic                  in_rdy;
    logic                  drain_almfull;
    logic                  ena;
    logic                  acc_res;
    logic                  acc_fin;
    logic                  acc_stop;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
    logic [31:0]           perf_stall;

    modport master (
        output start, cfg_num_vec, cfg_num_pass, in_valid, drain_almfull,
        input  in_rdy, ena, acc_res, acc_fin, acc_stop, busy, done, cfg_err,
               perf_stall
    );

    modport slave (
        input  start, cfg_num_vec, cfg_num_pass, in_valid, drain_almfull,
        output in_rdy, ena, acc_res, acc_fin, acc_stop, busy, done, cfg_err,
               perf_stall
    );
endinterface

// File: rtl/pe_sequencer.sv
// pe_sequencer
// ------------
// Job-level sequencer for the systolic PE array's accumulate loop. One job
// walks an output tile through num_pass K-blocks of num_vec vectors each and
// drives the PE central controls (ena, acc_res, acc_fin, acc_stop) so every
// PE feedback FIFO holds exactly one pass of partial sums. Between passes it
// inserts idle cycles so feedback data written DOT_DELAY cycles after issue
// is always present when the next pass reads it, and in the final pass it
// honours the drain FIFO's almost-full back-pressure.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   seq_if : pe_sequencer_if.slave (start/cfg, in_valid/in_rdy handshake,
//            drain_almfull, ena/acc_* PE controls, busy/done/cfg_err status,
//            perf_stall counter)
//
// Optional feature macro: PE_SEQ_PERF_EN
//   defined   : perf_stall counts RUN/GAP cycles without an issue, clears on an
//               accepted start and saturates at 2^32-1.
//   undefined : perf_stall is tied to 0.
module pe_sequencer #(
    parameter int DOT_DELAY  = 11,
    parameter int FEED_DEPTH = 1024,
    parameter int PASS_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pe_sequencer_if.slave  seq_if
);
    localparam int VEC_W = $clog2(FEED_DEPTH + 1);
    localparam int TMR_W = $clog2(DOT_DELAY + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        FLUSH
    } state_e;

    state_e                state_q, state_d;
    logic [VEC_W-1:0]      vec_cnt_q, vec_cnt_d;
    logic [VEC_W-1:0]      num_vec_q, num_vec_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [PASS_WIDTH-1:0] num_pass_q, num_pass_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  in_rdy;
    logic                  ena;
    logic                  last_vec;
    logic                  last_pass;
    logic                  tmr_zero;
    logic                  cfg_bad;
    logic                  has_gap;
    logic [31:0]           nv32;
    logic [TMR_W-1:0]      gap_m1;

    // Pass-position decodes. pass_cnt is deliberately not advanced past the
    // final pass, so last_pass stays true through FLUSH and acc_fin holds.
    assign last_vec  = (vec_cnt_q == num_vec_q - VEC_W'(1));
    assign last_pass = (pass_cnt_q == num_pass_q - PASS_WIDTH'(1));
    assign tmr_zero  = (tmr_q == '0);

    // Turnaround gap = DOT_DELAY+1-num_vec; the timer is loaded with gap-1.
    assign nv32    = 32'(num_vec_q);
    assign has_gap = (nv32 < 32'(DOT_DELAY + 1));
    assign gap_m1  = TMR_W'(32'(DOT_DELAY) - nv32);

    assign cfg_bad = (seq_if.cfg_num_vec == '0)
                   || (32'(seq_if.cfg_num_vec) > 32'(FEED_DEPTH))
                   || (seq_if.cfg_num_pass == '0);

    // Issue handshake and pass-level controls come only from registered state
    // plus in_valid/drain_almfull; the drain only gates the final pass.
    assign in_rdy = (state_q == RUN) && !(last_pass && seq_if.drain_almfull);
    assign ena    = in_rdy && seq_if.in_valid;

    assign seq_if.in_rdy   = in_rdy;
    assign seq_if.ena      = ena;
    assign seq_if.acc_res  = ((state_q == RUN) || (state_q == GAP)) && (pass_cnt_q != '0);
    assign seq_if.acc_fin  = (state_q != IDLE) && last_pass;
    assign seq_if.busy     = (state_q != IDLE);
    assign seq_if.done     = (state_q == FLUSH) && tmr_zero;
    assign seq_if.acc_stop = (state_q == FLUSH) && tmr_zero;
    assign seq_if.cfg_err  = cfg_err_q;

    // State and counter registers; reset drops every output to 0 at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_cnt_q  <= '0;
            num_vec_q  <= '0;
            pass_cnt_q <= '0;
            num_pass_q <= '0;
            tmr_q      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_cnt_q  <= vec_cnt_d;
            num_vec_q  <= num_vec_d;
            pass_cnt_q <= pass_cnt_d;
            num_pass_q <= num_pass_d;
            tmr_q      <= tmr_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Next-state logic: accept/reject jobs in IDLE, count issues in RUN,
    // hold off the next pass in GAP and wait out the PE pipeline in FLUSH.
    always_comb begin
        state_d    = state_q;
        vec_cnt_d  = vec_cnt_q;
        num_vec_d  = num_vec_q;
        pass_cnt_d = pass_cnt_q;
        num_pass_d = num_pass_q;
        tmr_d      = tmr_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (seq_if.start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        num_vec_d  = seq_if.cfg_num_vec;
                        num_pass_d = seq_if.cfg_num_pass;
                        vec_cnt_d  = '0;
                        pass_cnt_d = '0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                if (ena) begin
                    if (last_vec) begin
                        vec_cnt_d = '0;
                        if (last_pass) begin
                            tmr_d   = TMR_W'(DOT_DELAY);
                            state_d = FLUSH;
                        end else begin
                            pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                            if (has_gap) begin
                                tmr_d   = gap_m1;
                                state_d = GAP;
                            end
                        end
                    end else begin
                        vec_cnt_d = vec_cnt_q + VEC_W'(1);
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            FLUSH: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PE_SEQ_PERF_EN
    logic        start_ok;
    logic [31:0] perf_q;

    assign start_ok = (state_q == IDLE) && seq_if.start && !cfg_bad;

    // Stall counter: RUN/GAP cycles without an issue, saturating, cleared
    // when a new job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (((state_q == RUN) || (state_q == GAP)) && !ena && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign seq_if.perf_stall = perf_q;
`else
    assign seq_if.perf_stall = 32'd0;
`endif

endmodule
